// File: rtl/grf_write_arbiter.sv
// grf_write_arbiter
//
// Purpose:
//   Shares the single GRF write port between the pipeline W stage (p_*) and
//   the multiply/divide result path (m_*). MDU results are held in an
//   in-order FIFO. The pipeline normally wins the write port. If a non-empty
//   FIFO goes STARVE_LIMIT cycles without a pop, the next cycle forces an MDU
//   drain and stalls the pipeline. The winning write is registered and drives
//   the GRF directly on the following cycle. q_hit tells the hazard unit
//   whether any buffered MDU entry targets q_ra.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   p_valid/p_ready          pipeline write request / accepted this cycle
//   p_pc, p_wa, p_wd         pipeline write PC, destination, data
//   m_valid/m_ready          MDU result request / FIFO can accept
//   m_pc, m_wa, m_wd         MDU result PC, destination, data
//   grf_we/wa/wd/pc          registered GRF write port (pc for trace)
//   q_ra, q_hit              hazard lookup: buffered entry targets q_ra
//   fifo_count               current FIFO occupancy
module grf_write_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3,
    parameter int CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             p_valid,
    output logic             p_ready,
    input  logic [31:0]      p_pc,
    input  logic [4:0]       p_wa,
    input  logic [31:0]      p_wd,
    input  logic             m_valid,
    output logic             m_ready,
    input  logic [31:0]      m_pc,
    input  logic [4:0]       m_wa,
    input  logic [31:0]      m_wd,
    output logic             grf_we,
    output logic [4:0]       grf_wa,
    output logic [31:0]      grf_wd,
    output logic [31:0]      grf_pc,
    input  logic [4:0]       q_ra,
    output logic             q_hit,
    output logic [CNT_W-1:0] fifo_count
);

    localparam int              PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [3:0]       LIMIT_C = 4'(STARVE_LIMIT);

    // FIFO storage and bookkeeping
    logic [31:0]      r_memPc [DEPTH];
    logic [4:0]       r_memWa [DEPTH];
    logic [31:0]      r_memWd [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic [3:0]       r_starveCnt;

    // Registered GRF write port
    logic             r_grfWe;
    logic [4:0]       r_grfWa;
    logic [31:0]      r_grfWd;
    logic [31:0]      r_grfPc;

    logic             w_notEmpty;
    logic             w_force;
    logic             w_pipeGrant;
    logic             w_pop;
    logic             w_push;
    logic             w_qHit;
    logic [PTR_W-1:0] w_offset;

    // Grant selection works only on current state, so a result pushed this
    // cycle can never be popped in the same cycle. Full FIFO refuses new
    // results even when a pop happens alongside.
    always_comb begin
        w_notEmpty  = (r_count != '0);
        w_force     = w_notEmpty && (r_starveCnt >= LIMIT_C);
        w_pipeGrant = !w_force && p_valid;
        w_pop       = w_notEmpty && (w_force || !p_valid);
        w_push      = m_valid && (r_count < DEPTH_C) && (m_wa != 5'd0);
    end

    // An entry slot is occupied when its distance from the head, modulo the
    // FIFO depth, is below the current occupancy.
    always_comb begin
        w_qHit   = 1'b0;
        w_offset = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_offset = PTR_W'(i) - r_head;
            if ((CNT_W'(w_offset) < r_count) && (r_memWa[i] == q_ra) && (q_ra != 5'd0)) begin
                w_qHit = 1'b1;
            end
        end
    end

    // FIFO payload storage; contents are meaningless until counted as
    // occupied, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_memPc[r_tail] <= m_pc;
            r_memWa[r_tail] <= m_wa;
            r_memWd[r_tail] <= m_wd;
        end
    end

    // Pointers, occupancy, starvation counter and the registered write port.
    // The starvation counter looks at occupancy before the edge: a result
    // pushed into an empty FIFO starts counting from the cycle after.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_starveCnt <= 4'd0;
            r_grfWe     <= 1'b0;
            r_grfWa     <= 5'd0;
            r_grfWd     <= 32'd0;
            r_grfPc     <= 32'd0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase

            if (w_pop || !w_notEmpty) begin
                r_starveCnt <= 4'd0;
            end else if (r_starveCnt < LIMIT_C) begin
                r_starveCnt <= r_starveCnt + 4'd1;
            end

            // A pipe grant to $0 uses up the slot but writes nothing.
            if (w_pipeGrant) begin
                r_grfWe <= (p_wa != 5'd0);
                if (p_wa != 5'd0) begin
                    r_grfWa <= p_wa;
                    r_grfWd <= p_wd;
                    r_grfPc <= p_pc;
                end
            end else if (w_pop) begin
                r_grfWe <= 1'b1;
                r_grfWa <= r_memWa[r_head];
                r_grfWd <= r_memWd[r_head];
                r_grfPc <= r_memPc[r_head];
            end else begin
                r_grfWe <= 1'b0;
            end
        end
    end

    assign p_ready    = !w_force;
    assign m_ready    = (r_count < DEPTH_C);
    assign q_hit      = w_qHit;
    assign fifo_count = r_count;
    assign grf_we     = r_grfWe;
    assign grf_wa     = r_grfWa;
    assign grf_wd     = r_grfWd;
    assign grf_pc     = r_grfPc;

endmodule
